// File: rtl/axis_demux_1_2.sv
// Packet-aware 1:2 valid/ready demux; route latched at packet start so a sweep never splits.
// Latency: 1 cycle from input accept to Mx_VALID (one register stage per output port).
// Backpressure: S_READY follows the selected port's buffer (empty or draining); the other port drains independently.
module axis_demux_1_2 #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  D_SEL,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_VALID,
    input  logic                  S_LAST,
    output logic                  S_READY,
    output logic [DATA_WIDTH-1:0] M0_DATA,
    output logic                  M0_VALID,
    output logic                  M0_LAST,
    input  logic                  M0_READY,
    output logic [DATA_WIDTH-1:0] M1_DATA,
    output logic                  M1_VALID,
    output logic                  M1_LAST,
    input  logic                  M1_READY,
    output logic                  D_ROUTE,
    output logic                  D_BUSY,
    output logic [CNT_WIDTH-1:0]  PKT_CNT0,
    output logic [CNT_WIDTH-1:0]  PKT_CNT1
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  route_q, route_d;

    logic                  m0_vld_q, m0_vld_d;
    logic                  m0_last_q, m0_last_d;
    logic [DATA_WIDTH-1:0] m0_dat_q, m0_dat_d;
    logic                  m1_vld_q, m1_vld_d;
    logic                  m1_last_q, m1_last_d;
    logic [DATA_WIDTH-1:0] m1_dat_q, m1_dat_d;

    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

    logic                  route_eff;
    logic                  sel_vld;
    logic                  sel_rdy;
    logic                  s_rdy;
    logic                  accept;
    logic                  load0;
    logic                  load1;

    // In IDLE the request is live so the first beat of a packet already goes the right way.
    assign route_eff = (state_q == ST_IN_PKT) ? route_q : D_SEL;
    assign sel_vld   = route_eff ? m1_vld_q : m0_vld_q;
    assign sel_rdy   = route_eff ? M1_READY : M0_READY;
    assign s_rdy     = RSTN && (!sel_vld || sel_rdy);
    assign accept    = S_VALID && s_rdy;
    assign load0     = accept && !route_eff;
    assign load1     = accept && route_eff;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (!S_LAST) begin
                    state_d = ST_IN_PKT;
                    route_d = D_SEL;
                end
            end else if (S_LAST) begin
                state_d = ST_IDLE;
            end
        end
    end

    // A load wins over a drain, so a simultaneous drain+load keeps VALID high with new data.
    always_comb begin
        m0_vld_d  = m0_vld_q;
        m0_last_d = m0_last_q;
        m0_dat_d  = m0_dat_q;
        if (load0) begin
            m0_vld_d  = 1'b1;
            m0_last_d = S_LAST;
            m0_dat_d  = S_DATA;
        end else if (M0_READY) begin
            m0_vld_d  = 1'b0;
        end
    end

    always_comb begin
        m1_vld_d  = m1_vld_q;
        m1_last_d = m1_last_q;
        m1_dat_d  = m1_dat_q;
        if (load1) begin
            m1_vld_d  = 1'b1;
            m1_last_d = S_LAST;
            m1_dat_d  = S_DATA;
        end else if (M1_READY) begin
            m1_vld_d  = 1'b0;
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (m0_vld_q && M0_READY && m0_last_q) begin
            cnt0_d = cnt0_q + CNT_WIDTH'(1);
        end
        if (m1_vld_q && M1_READY && m1_last_q) begin
            cnt1_d = cnt1_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            route_q   <= 1'b0;
            m0_vld_q  <= 1'b0;
            m0_last_q <= 1'b0;
            m0_dat_q  <= '0;
            m1_vld_q  <= 1'b0;
            m1_last_q <= 1'b0;
            m1_dat_q  <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            m0_vld_q  <= m0_vld_d;
            m0_last_q <= m0_last_d;
            m0_dat_q  <= m0_dat_d;
            m1_vld_q  <= m1_vld_d;
            m1_last_q <= m1_last_d;
            m1_dat_q  <= m1_dat_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign S_READY  = s_rdy;
    assign M0_DATA  = m0_dat_q;
    assign M0_VALID = m0_vld_q;
    assign M0_LAST  = m0_last_q;
    assign M1_DATA  = m1_dat_q;
    assign M1_VALID = m1_vld_q;
    assign M1_LAST  = m1_last_q;
    assign D_ROUTE  = route_eff;
    assign D_BUSY   = (state_q == ST_IN_PKT);
    assign PKT_CNT0 = cnt0_q;
    assign PKT_CNT1 = cnt1_q;

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Bench for axis_demux_1_2: directed vector table, reset/wrap sequences, randomized traffic vs queue model.
module tb_axis_demux_1_2;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rstn;
    logic          d_sel;
    logic [DW-1:0] s_dat;
    logic          s_vld;
    logic          s_last;
    logic          s_rdy;
    logic [DW-1:0] m0_dat;
    logic          m0_vld;
    logic          m0_last;
    logic          m0_rdy;
    logic [DW-1:0] m1_dat;
    logic          m1_vld;
    logic          m1_last;
    logic          m1_rdy;
    logic          d_route;
    logic          d_busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    axis_demux_1_2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK(clk), .RSTN(rstn), .D_SEL(d_sel),
        .S_DATA(s_dat), .S_VALID(s_vld), .S_LAST(s_last), .S_READY(s_rdy),
        .M0_DATA(m0_dat), .M0_VALID(m0_vld), .M0_LAST(m0_last), .M0_READY(m0_rdy),
        .M1_DATA(m1_dat), .M1_VALID(m1_vld), .M1_LAST(m1_last), .M1_READY(m1_rdy),
        .D_ROUTE(d_route), .D_BUSY(d_busy), .PKT_CNT0(cnt0), .PKT_CNT1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] dat;
        logic        vld, last, r0, r1;
        logic        e_rdy, e_m0v;
        logic [31:0] e_m0d;
        logic        e_m1v;
        logic [31:0] e_m1d;
        logic        e_busy;
        logic [3:0]  e_c0, e_c1;
    } vec_t;

    vec_t tbl[12];

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    bit    in_pkt, pkt_route, route, exp_rdy, acc;
    int    c0m, c1m;

    task automatic drive_idle();
        d_sel = 1'b0; s_dat = '0; s_vld = 1'b0; s_last = 1'b0;
        m0_rdy = 1'b1; m1_rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        //           sel dat    vld last r0 r1  rdy m0v m0d    m1v m1d    busy c0 c1
        tbl[0]  = '{1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0,  1'b1, 4'd0, 4'd0};
        tbl[1]  = '{1'b0, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0,  1'b1, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, 32'h12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12, 1'b0, 32'h0,  1'b1, 4'd0, 4'd0};
        tbl[3]  = '{1'b1, 32'h13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 32'h0,  1'b0, 4'd0, 4'd0};
        tbl[4]  = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 4'd1, 4'd0};
        tbl[5]  = '{1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 4'd1, 4'd0};
        tbl[6]  = '{1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 4'd1, 4'd0};
        tbl[7]  = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 4'd1, 4'd1};
        tbl[8]  = '{1'b0, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0,  1'b0, 4'd1, 4'd1};
        tbl[9]  = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 32'h40, 1'b1, 4'd1, 4'd1};
        tbl[10] = '{1'b0, 32'h41, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 32'h41, 1'b0, 4'd1, 4'd1};
        tbl[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 4'd2, 4'd2};

        rstn = 1'b0;
        drive_idle();
        #3;
        chk("rst_s_ready", 32'(s_rdy), 32'd0);
        chk("rst_m0_valid", 32'(m0_vld), 32'd0);
        chk("rst_m1_valid", 32'(m1_vld), 32'd0);
        chk("rst_m0_data", m0_dat, 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table: basic route, mid-packet select change, stall, independent drain.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d_sel = tbl[i].sel; s_dat = tbl[i].dat; s_vld = tbl[i].vld;
            s_last = tbl[i].last; m0_rdy = tbl[i].r0; m1_rdy = tbl[i].r1;
            #1;
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_m0_valid", i), 32'(m0_vld), 32'(tbl[i].e_m0v));
            if (tbl[i].e_m0v) chk($sformatf("tbl%0d_m0_data", i), m0_dat, tbl[i].e_m0d);
            chk($sformatf("tbl%0d_m1_valid", i), 32'(m1_vld), 32'(tbl[i].e_m1v));
            if (tbl[i].e_m1v) chk($sformatf("tbl%0d_m1_data", i), m1_dat, tbl[i].e_m1d);
            chk($sformatf("tbl%0d_busy", i), 32'(d_busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_cnt0", i), 32'(cnt0), 32'(tbl[i].e_c0));
            chk($sformatf("tbl%0d_cnt1", i), 32'(cnt1), 32'(tbl[i].e_c1));
        end
        chk("tbl_m0_last_on_final", 32'(m0_last), 32'd1);

        // Async reset in the middle of beat 2 of a packet on M0.
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            d_sel = 1'b0; s_vld = 1'b1; s_last = 1'b0; s_dat = 32'h50 + 32'(b);
            m0_rdy = 1'b0; m1_rdy = 1'b0;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_s_ready", 32'(s_rdy), 32'd0);
        chk("arst_m0_valid", 32'(m0_vld), 32'd0);
        chk("arst_m1_valid", 32'(m1_vld), 32'd0);
        chk("arst_busy", 32'(d_busy), 32'd0);
        chk("arst_cnt0", 32'(cnt0), 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;
        @(negedge clk);
        d_sel = 1'b1; s_vld = 1'b1; s_last = 1'b1; s_dat = 32'h77; m1_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_m1_valid", 32'(m1_vld), 32'd1);
        chk("post_rst_m1_data", m1_dat, 32'h77);
        chk("post_rst_m0_valid", 32'(m0_vld), 32'd0);

        // 17 single-beat packets on M0: state never leaves IDLE, counter wraps to 1.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            d_sel = 1'b0; s_vld = 1'b1; s_last = 1'b1; s_dat = 32'h100 + 32'(k);
            m0_rdy = 1'b1; m1_rdy = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_busy", k), 32'(d_busy), 32'd0);
        end
        @(negedge clk);
        s_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_cnt0", 32'(cnt0), 32'd1);
        chk("wrap_cnt1", 32'(cnt1), 32'd1);

        // Randomized traffic against a queue-based model.
        do_reset();
        q0.delete(); q1.delete();
        in_pkt = 1'b0; pkt_route = 1'b0; c0m = 0; c1m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            d_sel  = 1'($urandom_range(0, 1));
            s_vld  = ($urandom_range(0, 3) != 0);
            s_last = ($urandom_range(0, 3) == 0);
            s_dat  = $urandom;
            m0_rdy = ($urandom_range(0, 2) != 0);
            m1_rdy = ($urandom_range(0, 2) != 0);
            #1;
            route   = in_pkt ? pkt_route : d_sel;
            exp_rdy = route ? (q1.size() == 0 || m1_rdy) : (q0.size() == 0 || m0_rdy);
            chk("rnd_s_ready", 32'(s_rdy), 32'(exp_rdy));
            chk("rnd_route", 32'(d_route), 32'(route));
            chk("rnd_busy", 32'(d_busy), 32'(in_pkt));
            chk("rnd_m0_valid", 32'(m0_vld), 32'(q0.size() != 0));
            chk("rnd_m1_valid", 32'(m1_vld), 32'(q1.size() != 0));
            if (q0.size() != 0) begin
                chk("rnd_m0_data", m0_dat, q0[0].d);
                chk("rnd_m0_last", 32'(m0_last), 32'(q0[0].l));
            end
            if (q1.size() != 0) begin
                chk("rnd_m1_data", m1_dat, q1[0].d);
                chk("rnd_m1_last", 32'(m1_last), 32'(q1[0].l));
            end
            chk("rnd_cnt0", 32'(cnt0), 32'(c0m));
            chk("rnd_cnt1", 32'(cnt1), 32'(c1m));

            acc = s_vld && exp_rdy;
            if (q0.size() != 0 && m0_rdy) begin
                if (q0[0].l) c0m = (c0m + 1) % 16;
                void'(q0.pop_front());
            end
            if (q1.size() != 0 && m1_rdy) begin
                if (q1[0].l) c1m = (c1m + 1) % 16;
                void'(q1.pop_front());
            end
            if (acc) begin
                if (route) q1.push_back({s_dat, s_last});
                else       q0.push_back({s_dat, s_last});
                if (!in_pkt && !s_last) begin
                    in_pkt = 1'b1;
                    pkt_route = d_sel;
                end else if (in_pkt && s_last) begin
                    in_pkt = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_demux_1_2.md
Name: axis_demux_1_2

Overview:
- Packet-aware 1:2 stream demultiplexer: the receiving-side counterpart of the 2:1 signal mux in the radar simulator datapath.
- Routes a single valid/ready sample stream (target/clutter samples, S_LAST marks end of a radar sweep) to one of two downstream consumers.
- The route is selected by D_SEL and latched at packet boundaries, so a sweep is never split across outputs.
- One registered output stage per port; per-output packet counters for software/debug visibility.

Parameters:
- DATA_WIDTH, 32, width of sample data bus.
- CNT_WIDTH, 16, width of per-output packet counters.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- D_SEL  in  1  route request: 0 selects M0, 1 selects M1; sampled only at packet start.
- S_DATA  in  DATA_WIDTH  input sample.
- S_VALID  in  1  input beat valid.
- S_LAST  in  1  last beat of packet.
- S_READY  out  1  input beat accepted when S_VALID && S_READY.
- M0_DATA  out  DATA_WIDTH  output 0 sample.
- M0_VALID  out  1  output 0 beat valid.
- M0_LAST  out  1  output 0 last beat.
- M0_READY  in  1  output 0 consumer ready.
- M1_DATA, M1_VALID, M1_LAST, M1_READY: same as M0 for output 1.
- D_ROUTE  out  1  route currently in use (latched or, in IDLE, D_SEL).
- D_BUSY  out  1  1 while inside a packet (state IN_PKT).
- PKT_CNT0  out  CNT_WIDTH  packets completed on M0.
- PKT_CNT1  out  CNT_WIDTH  packets completed on M1.

Behaviour:
- Reset (RSTN=0, async):
  - State is IDLE; route register is 0.
  - M0/M1 VALID, LAST and DATA are 0; PKT_CNT0/1 are 0; D_BUSY is 0.
  - S_READY is forced 0 while RSTN=0.
- States:
  - IDLE: route_eff = D_SEL.
  - IN_PKT: route_eff = latched route register.
- Transitions:
  - IDLE, beat accepted with S_LAST=0 -> latch route=D_SEL, go to IN_PKT.
  - IDLE, beat accepted with S_LAST=1 -> stay IDLE (single-beat packet).
  - IN_PKT, beat accepted with S_LAST=1 -> IDLE next cycle.
  - Any other cycle: hold state.
- D_SEL changes while in IN_PKT are ignored until the packet's LAST beat is accepted.
- Output buffer per port:
  - S_READY = RSTN && (!Mx_VALID || Mx_READY) for x = route_eff; combinational, allowing 1 beat/cycle throughput.
  - On accept: Mx_DATA/Mx_LAST load S_DATA/S_LAST and Mx_VALID=1 on the next edge (latency 1 cycle).
  - Mx_VALID clears when Mx_READY=1 and no new beat is loaded in the same cycle.
  - Simultaneous drain and load on the same port: VALID stays 1 and data is replaced.
- While Mx_VALID=1 && Mx_READY=0: Mx_DATA and Mx_LAST hold stable.
- The unselected port keeps draining its pending beat independently; its buffer is never written.
- PKT_CNTx increments by 1 when Mx_VALID && Mx_READY && Mx_LAST; wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-packet: buffers and state are cleared immediately and the partial packet is discarded. Downstream sees VALID drop with no LAST, and counters reset.
- No X propagation: S_DATA is not loaded unless the beat is accepted.

Test Plan:
- Basic route: D_SEL=0, send 4-beat packet 0x10..0x13, M0_READY=1 -> M0 shows 0x10..0x13 one cycle after each accept, M0_LAST on 0x13, PKT_CNT0=1, M1_VALID never 1.
- Mid-packet select change: D_SEL=0 at beat 0, set D_SEL=1 at beat 2 of a 5-beat packet -> all 5 beats on M0. The next packet goes to M1, PKT_CNT0=1, PKT_CNT1=1.
- Backpressure: route to M1, M1_READY=0 for 3 cycles after first beat -> S_READY=0 during stall, M1_DATA stable; after release, full throughput with no beat lost or duplicated.
- Independent drain: M0 holds a pending beat with M0_READY=0 while a packet is routed to M1 -> M1 stream flows at 1 beat/cycle; M0 beat is delivered unchanged when M0_READY rises.
- Single-beat packets and wrap: CNT_WIDTH=4, send 17 one-beat LAST packets to M0 -> state stays IDLE throughout, PKT_CNT0 = 1 after wrap.
- Async reset mid-packet: deassert RSTN between clock edges during beat 2 -> M0_VALID/M1_VALID=0 and S_READY=0 immediately, counters 0. After release, a new packet routes per D_SEL.
